alu_writeback_queue: RTL

Writeback stage directly downstream of the ALU output mux. Captures the selected 8-bit result plus its C/N/V/Z flags into a small in-order FIFO. Presents the head entry to the register-file write port over a valid/ready handshake. Commits masked flags into the condition-code register (CCR) only when the entry retires, so the CCR always reflects architecturally retired operations.

---
 rtl/alu_writeback_queue.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_writeback_queue.sv
// In-order writeback queue between the ALU output mux and the register-file write port; retiring entries commit masked flags to the CCR.
// Latency: an entry pushed at edge k is presented on o_wb_* in cycle k+1; CCR/SV update the cycle after the retiring edge.
// Backpressure: o_in_ready drops when full (registered state only); entries hold at the head while i_wb_ready is low.
// Optional feature: define STICKY_OVF_EN to build the sticky-overflow bit (o_sv, cleared by i_clr_sv).
module alu_writeback_queue #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 3,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [7:0]        i_din,
  input  logic              i_c,
  input  logic              i_n,
  input  logic              i_v,
  input  logic              i_z,
  input  logic [3:0]        i_flag_mask,
  input  logic [ADDR_W-1:0] i_dest,
  input  logic              i_flush,
  output logic              o_wb_valid,
  input  logic              i_wb_ready,
  output logic [7:0]        o_wb_data,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [3:0]        o_ccr,
  output logic [CNT_W-1:0]  o_count,
  input  logic              i_clr_sv,
  output logic              o_sv
);

  localparam int PTR_W = $clog2(DEPTH);

  // Flag nibble order matches the CCR: bit0=C, bit1=N, bit2=V, bit3=Z.
  typedef struct packed {
    logic [7:0]        data;
    logic [3:0]        flags;
    logic [3:0]        mask;
    logic [ADDR_W-1:0] dest;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [3:0]         r_ccr;

  entry_t             w_in_entry;
  entry_t             w_head;
  logic               w_in_ready;
  logic               w_wb_valid;
  logic               w_push;
  logic               w_pop;

  // Ready/valid derive from the registered count only, so no combinational
  // path exists from i_wb_ready to o_in_ready or from i_in_valid to o_wb_valid.
  assign w_in_ready = (r_count < CNT_W'(DEPTH));
  assign w_wb_valid = (r_count != '0);

  // Flush wins over both transfers; nothing retires in a flush cycle.
  assign w_push = i_in_valid && w_in_ready && !i_flush;
  assign w_pop  = w_wb_valid && i_wb_ready && !i_flush;

  assign w_in_entry = '{data: i_din, flags: {i_z, i_v, i_n, i_c}, mask: i_flag_mask, dest: i_dest};
  assign w_head     = r_mem[r_rd_ptr];

  assign o_in_ready = w_in_ready;
  assign o_wb_valid = w_wb_valid;
  // Empty queue presents zeros rather than stale or uninitialised storage.
  assign o_wb_data  = w_wb_valid ? w_head.data : 8'h00;
  assign o_wb_addr  = w_wb_valid ? w_head.dest : '0;
  assign o_ccr      = r_ccr;
  assign o_count    = r_count;

  // Entry storage: payload only, validity is tracked by the count/pointers.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // CCR commits only the masked flags of the retiring entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ccr <= 4'b0000;
    end else if (w_pop) begin
      r_ccr <= (r_ccr & ~w_head.mask) | (w_head.flags & w_head.mask);
    end
  end

`ifdef STICKY_OVF_EN
  logic r_sv;

  // Sticky overflow: a retiring masked V=1 sets it, and setting beats clearing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sv <= 1'b0;
    end else if (w_pop && w_head.mask[2] && w_head.flags[2]) begin
      r_sv <= 1'b1;
    end else if (i_clr_sv) begin
      r_sv <= 1'b0;
    end
  end

  assign o_sv = r_sv;
`else
  logic w_unused_clr_sv;

  assign w_unused_clr_sv = i_clr_sv;
  assign o_sv            = 1'b0;
`endif

endmodule
